atomik_h264_delta_extractor: RTL

//  Upstream feeder for the H.264 delta accumulator. Takes a frame of DEPTH words (valid/ready),

---
 rtl/atomik_h264_delta_extractor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/atomik_h264_delta_extractor.sv
// H.264 delta extractor: turns incoming frames into LOAD/ACCUMULATE commands for the delta
// accumulator, keeping the previous frame as the XOR reference for delta frames.
module atomik_h264_delta_extractor #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned DEPTH      = 16,
   parameter bit          SKIP_ZERO  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH-1:0]      s_data,
   input  logic                       s_sof,
   input  logic                       s_key,
   output logic                       load_en,
   output logic                       accumulate_en,
   output logic [DATA_WIDTH-1:0]      acc_data,
   output logic                       frame_done,
   output logic                       frame_err,
   output logic [$clog2(DEPTH+1)-1:0] nz_count
);

   localparam int unsigned       SLOT_W    = $clog2(DEPTH);
   localparam int unsigned       NZ_W      = $clog2(DEPTH + 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_FRAME
   } state_t;

   state_t                state_q, state_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic                  have_key_q, have_key_d;
   logic                  key_q, key_d;
   logic [NZ_W-1:0]       cnt_q, cnt_d;
   logic                  load_q, load_d;
   logic                  acc_q, acc_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [NZ_W-1:0]       nz_q, nz_d;

   logic [DATA_WIDTH-1:0] ref_q [DEPTH];
   logic                  ref_we;
   logic [SLOT_W-1:0]     ref_addr;
   logic [DATA_WIDTH-1:0] ref_wdata;

   logic                  xfer;
   logic                  start;
   logic                  key_eff;
   logic [SLOT_W-1:0]     idx;
   logic [DATA_WIDTH-1:0] delta;
   logic                  delta_nz;

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      have_key_d = have_key_q;
      key_d      = key_q;
      cnt_d      = cnt_q;
      load_d     = 1'b0;
      acc_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      data_d     = data_q;
      nz_d       = nz_q;
      ref_we     = 1'b0;
      ref_addr   = slot_q;
      ref_wdata  = '0;

      s_ready  = (state_q != ST_INIT);
      xfer     = s_valid & s_ready;
      start    = xfer & s_sof;
      // A start-of-frame always restarts at slot 0, even in the middle of a frame.
      key_eff  = start ? (s_key | ~have_key_q) : key_q;
      idx      = start ? '0 : slot_q;
      delta    = s_data ^ ref_q[idx];
      delta_nz = |delta;

      unique case (state_q)
         ST_INIT: begin
            ref_we    = 1'b1;
            ref_addr  = slot_q;
            ref_wdata = '0;
            if (slot_q == LAST_SLOT) begin
               slot_d  = '0;
               state_d = ST_IDLE;
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         ST_IDLE, ST_FRAME: begin
            if (xfer && (start || (state_q == ST_FRAME))) begin
               err_d     = start && (state_q == ST_FRAME);
               key_d     = key_eff;
               ref_we    = 1'b1;
               ref_addr  = idx;
               ref_wdata = s_data;
               if (key_eff) begin
                  load_d = (idx == '0);
                  acc_d  = (idx != '0);
                  data_d = s_data;
               end else if (delta_nz || !SKIP_ZERO) begin
                  acc_d  = 1'b1;
                  data_d = delta;
               end
               cnt_d = (start ? '0 : cnt_q) + NZ_W'(!key_eff && delta_nz);
               if (idx == LAST_SLOT) begin
                  done_d     = 1'b1;
                  nz_d       = cnt_d;
                  have_key_d = 1'b1;
                  slot_d     = '0;
                  state_d    = ST_IDLE;
               end else begin
                  slot_d  = idx + SLOT_W'(1);
                  state_d = ST_FRAME;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            slot_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         slot_q     <= '0;
         have_key_q <= 1'b0;
         key_q      <= 1'b0;
         cnt_q      <= '0;
         load_q     <= 1'b0;
         acc_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         data_q     <= '0;
         nz_q       <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         have_key_q <= have_key_d;
         key_q      <= key_d;
         cnt_q      <= cnt_d;
         load_q     <= load_d;
         acc_q      <= acc_d;
         done_q     <= done_d;
         err_q      <= err_d;
         data_q     <= data_d;
         nz_q       <= nz_d;
      end
   end

   // Reference contents are rebuilt by INIT after every reset, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (ref_we) begin
         ref_q[ref_addr] <= ref_wdata;
      end
   end

   assign load_en       = load_q;
   assign accumulate_en = acc_q;
   assign acc_data      = data_q;
   assign frame_done    = done_q;
   assign frame_err     = err_q;
   assign nz_count      = nz_q;

endmodule
